// File: rtl/sd_kopierer_pkg.sv
// Shared types and defaults for the SD-to-RAM bulk copy engine.
package sd_kopierer_pkg;

    localparam int unsigned ANZAHL_BREITE_DEF  = 16;
    localparam int unsigned TIMEOUT_BREITE_DEF = 24;

    typedef enum logic [2:0] {
        StIdle         = 3'd0,
        StSdAnfrage    = 3'd1,
        StSdStart      = 3'd2,
        StSdWarten     = 3'd3,
        StRamSchreiben = 3'd4,
        StSdFreigabe   = 3'd5
    } zustand_e;

    // States that wait on the SD reader and must not hang on a dead card.
    function automatic logic zeitueberwacht(input zustand_e z);
        return z inside {StSdAnfrage, StSdStart, StSdWarten, StSdFreigabe};
    endfunction

endpackage

// File: rtl/sd_kopierer_if.sv
// SD reader request/response and RAM write port as seen by the copy engine.
interface sd_kopierer_if;

    logic [31:0] sd_adresse;
    logic        sd_lesen;
    logic [31:0] sd_daten;
    logic        sd_fertig;
    logic        sd_busy;

    logic [31:0] ram_adresse;
    logic [31:0] ram_daten;
    logic        ram_schreiben;
    logic        ram_bereit;

    modport master (
        output sd_adresse, sd_lesen, ram_adresse, ram_daten, ram_schreiben,
        input  sd_daten, sd_fertig, sd_busy, ram_bereit
    );

    modport slave (
        input  sd_adresse, sd_lesen, ram_adresse, ram_daten, ram_schreiben,
        output sd_daten, sd_fertig, sd_busy, ram_bereit
    );

endinterface

// File: rtl/sd_zeitgeber.sv
// Clearable saturating wait counter; abgelaufen is high once it reaches all-ones.
module sd_zeitgeber #(
    parameter int unsigned BREITE = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic zaehlen,
    input  logic loeschen,
    output logic abgelaufen
);

    logic [BREITE-1:0] zaehler_q;

    assign abgelaufen = &zaehler_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zaehler_q <= '0;
        end else if (loeschen) begin
            zaehler_q <= '0;
        end else if (zaehlen && !abgelaufen) begin
            zaehler_q <= zaehler_q + BREITE'(1);
        end
    end

endmodule

// File: rtl/sd_kopierer.sv
// Copies a run of words from the SD word reader into RAM, one read request per word,
// with a per-state timeout so a dead card ends in an error flag instead of a hang.
module sd_kopierer
    import sd_kopierer_pkg::*;
#(
    parameter int unsigned ANZAHL_BREITE  = ANZAHL_BREITE_DEF,
    parameter int unsigned TIMEOUT_BREITE = TIMEOUT_BREITE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [31:0]              quell_adresse,
    input  logic [31:0]              ziel_adresse,
    input  logic [ANZAHL_BREITE-1:0] anzahl,
    output logic                     busy,
    output logic                     fertig,
    output logic                     fehler,
    sd_kopierer_if.master            bus
);

    zustand_e state_q, state_d;

    logic [31:0]              src_q, src_d;
    logic [31:0]              dst_q, dst_d;
    logic [ANZAHL_BREITE-1:0] rest_q, rest_d;
    logic                     busy_q, busy_d;
    logic                     fertig_q, fertig_d;
    logic                     fehler_q, fehler_d;
    logic [31:0]              sd_adresse_q, sd_adresse_d;
    logic                     sd_lesen_q, sd_lesen_d;
    logic [31:0]              ram_adresse_q, ram_adresse_d;
    logic [31:0]              ram_daten_q, ram_daten_d;
    logic                     ram_schreiben_q, ram_schreiben_d;

    logic sd_frei;
    logic zeit_aktiv;
    logic zeit_ab;
    logic timeout;

    // Reader is idle only once it has also dropped the data-valid of its last sector.
    assign sd_frei    = !bus.sd_busy && !bus.sd_fertig;
    assign zeit_aktiv = zeitueberwacht(state_q);
    assign timeout    = zeit_aktiv && zeit_ab;

    sd_zeitgeber #(
        .BREITE (TIMEOUT_BREITE)
    ) u_zeitgeber (
        .clk        (clk),
        .rst_n      (rst_n),
        .zaehlen    (zeit_aktiv),
        .loeschen   (state_d != state_q),
        .abgelaufen (zeit_ab)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && (anzahl != '0)) begin
                    state_d = StSdAnfrage;
                end
            end
            StSdAnfrage:    if (sd_frei)        state_d = StSdStart;
            StSdStart:      if (bus.sd_busy)    state_d = StSdWarten;
            StSdWarten:     if (bus.sd_fertig)  state_d = StRamSchreiben;
            StRamSchreiben: if (bus.ram_bereit) state_d = StSdFreigabe;
            StSdFreigabe: begin
                if (sd_frei) begin
                    state_d = (rest_q == '0) ? StIdle : StSdAnfrage;
                end
            end
            default: state_d = StIdle;
        endcase
        if (timeout) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        src_d           = src_q;
        dst_d           = dst_q;
        rest_d          = rest_q;
        busy_d          = busy_q;
        fertig_d        = fertig_q;
        fehler_d        = fehler_q;
        sd_adresse_d    = sd_adresse_q;
        sd_lesen_d      = 1'b0;
        ram_adresse_d   = ram_adresse_q;
        ram_daten_d     = ram_daten_q;
        ram_schreiben_d = ram_schreiben_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_d    = quell_adresse;
                    dst_d    = ziel_adresse;
                    rest_d   = anzahl;
                    fehler_d = 1'b0;
                    fertig_d = (anzahl == '0);
                    busy_d   = (anzahl != '0);
                end
            end
            StSdAnfrage: begin
                if (sd_frei) begin
                    sd_adresse_d = src_q;
                    sd_lesen_d   = 1'b1;
                end
            end
            StSdWarten: begin
                if (bus.sd_fertig) begin
                    ram_daten_d     = bus.sd_daten;
                    ram_adresse_d   = dst_q;
                    ram_schreiben_d = 1'b1;
                end
            end
            StRamSchreiben: begin
                if (bus.ram_bereit) begin
                    ram_schreiben_d = 1'b0;
                    src_d           = src_q + 32'd1;
                    dst_d           = dst_q + 32'd1;
                    rest_d          = rest_q - ANZAHL_BREITE'(1);
                end
            end
            StSdFreigabe: begin
                if (sd_frei && (rest_q == '0)) begin
                    fertig_d = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            default: ;
        endcase
        // rest_q is deliberately left as-is so the remaining count is visible after an abort.
        if (timeout) begin
            fehler_d        = 1'b1;
            fertig_d        = 1'b0;
            busy_d          = 1'b0;
            sd_lesen_d      = 1'b0;
            ram_schreiben_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q           <= '0;
            dst_q           <= '0;
            rest_q          <= '0;
            busy_q          <= 1'b0;
            fertig_q        <= 1'b0;
            fehler_q        <= 1'b0;
            sd_adresse_q    <= '0;
            sd_lesen_q      <= 1'b0;
            ram_adresse_q   <= '0;
            ram_daten_q     <= '0;
            ram_schreiben_q <= 1'b0;
        end else begin
            src_q           <= src_d;
            dst_q           <= dst_d;
            rest_q          <= rest_d;
            busy_q          <= busy_d;
            fertig_q        <= fertig_d;
            fehler_q        <= fehler_d;
            sd_adresse_q    <= sd_adresse_d;
            sd_lesen_q      <= sd_lesen_d;
            ram_adresse_q   <= ram_adresse_d;
            ram_daten_q     <= ram_daten_d;
            ram_schreiben_q <= ram_schreiben_d;
        end
    end

    assign busy              = busy_q;
    assign fertig            = fertig_q;
    assign fehler            = fehler_q;
    assign bus.sd_adresse    = sd_adresse_q;
    assign bus.sd_lesen      = sd_lesen_q;
    assign bus.ram_adresse   = ram_adresse_q;
    assign bus.ram_daten     = ram_daten_q;
    assign bus.ram_schreiben = ram_schreiben_q;

endmodule

// File: tb/tb_sd_kopierer.sv
// Bench for sd_kopierer: SD reader model, stallable RAM, scoreboard of expected SD/RAM traffic.
module tb_sd_kopierer;

    typedef struct {
        logic [31:0] quell;
        logic [31:0] ziel;
        logic [15:0] anzahl;
        int          stall_wort;
        int          stall_len;
        logic        exp_fertig;
        logic        exp_fehler;
    } vec_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } ram_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] quell_adresse = '0;
    logic [31:0] ziel_adresse = '0;
    logic [15:0] anzahl = '0;
    logic        busy, fertig, fehler;

    sd_kopierer_if bus ();

    sd_kopierer #(
        .ANZAHL_BREITE  (16),
        .TIMEOUT_BREITE (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .quell_adresse (quell_adresse),
        .ziel_adresse  (ziel_adresse),
        .anzahl        (anzahl),
        .busy          (busy),
        .fertig        (fertig),
        .fehler        (fehler),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    int lesen_cnt = 0;
    ram_t        ram_q[$];
    logic [31:0] sd_q[$];

    task automatic pruefe(input string name, input logic [31:0] ist, input logic [31:0] soll);
        n_vec++;
        if (ist !== soll) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, ist, soll);
        end
    endtask

    // SD reader model: busy one cycle after the request, data valid for three cycles.
    logic        sd_tot = 1'b0;
    logic [31:0] sd_addr;
    int          sd_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sd_busy   <= 1'b0;
            bus.sd_fertig <= 1'b0;
            bus.sd_daten  <= '0;
            sd_addr       <= '0;
            sd_cnt        <= 0;
        end else if (bus.sd_lesen) begin
            sd_addr     <= bus.sd_adresse;
            bus.sd_busy <= 1'b1;
            sd_cnt      <= 0;
        end else if (bus.sd_busy) begin
            sd_cnt <= sd_cnt + 1;
            if (!sd_tot) begin
                if (sd_cnt == 2) begin
                    bus.sd_fertig <= 1'b1;
                    bus.sd_daten  <= sd_addr ^ 32'hA5A5_A5A5;
                end
                if (sd_cnt >= 5) begin
                    bus.sd_fertig <= 1'b0;
                    bus.sd_busy   <= 1'b0;
                end
            end
        end
    end

    // RAM model: refuses write number stall_wort for stall_len cycles.
    int stall_wort = -1;
    int stall_len = 0;
    int writes_done;
    int stall_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writes_done <= 0;
            stall_cnt   <= 0;
        end else if (start && !busy) begin
            writes_done <= 0;
            stall_cnt   <= 0;
        end else if (bus.ram_schreiben) begin
            if (bus.ram_bereit) writes_done <= writes_done + 1;
            else                stall_cnt   <= stall_cnt + 1;
        end
    end
    assign bus.ram_bereit = !(bus.ram_schreiben && writes_done == stall_wort
                              && stall_cnt < stall_len);

    logic        halt_q = 1'b0;
    logic [31:0] prev_adr, prev_dat;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.sd_lesen) begin
                lesen_cnt++;
                if (sd_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL sd_lesen: unexpected request, adresse %h", bus.sd_adresse);
                end else begin
                    pruefe("sd_adresse", bus.sd_adresse, sd_q.pop_front());
                end
            end
            if (halt_q) begin
                pruefe("ram_halten", 32'(bus.ram_schreiben), 32'd1);
                pruefe("ram_adr_stabil", bus.ram_adresse, prev_adr);
                pruefe("ram_dat_stabil", bus.ram_daten, prev_dat);
            end
            if (bus.ram_schreiben && bus.ram_bereit) begin
                if (ram_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL ram_write: unexpected write %h <= %h",
                             bus.ram_adresse, bus.ram_daten);
                end else begin
                    ram_t e;
                    e = ram_q.pop_front();
                    pruefe("ram_adresse", bus.ram_adresse, e.adr);
                    pruefe("ram_daten", bus.ram_daten, e.dat);
                end
            end
            halt_q   = bus.ram_schreiben && !bus.ram_bereit;
            prev_adr = bus.ram_adresse;
            prev_dat = bus.ram_daten;
        end else begin
            halt_q = 1'b0;
        end
    end

    task automatic erwarte(input logic [31:0] q, input logic [31:0] z, input int n, input int nram);
        for (int k = 0; k < n; k++) begin
            ram_t e;
            sd_q.push_back(q + 32'(k));
            e.adr = z + 32'(k);
            e.dat = (q + 32'(k)) ^ 32'hA5A5_A5A5;
            if (k < nram) ram_q.push_back(e);
        end
    endtask

    task automatic puls_start(input logic [31:0] q, input logic [31:0] z, input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        quell_adresse = q;
        ziel_adresse = z;
        anzahl = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic warte_ende(input string name, input int grenze, output int n);
        n = 0;
        while (!(!busy && (fertig || fehler)) && n < grenze) begin
            @(negedge clk);
            n++;
        end
        if (n >= grenze) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: no completion within %0d cycles", name, grenze);
        end
    endtask

    task automatic kopie(input vec_t v);
        int basis, dauer;
        erwarte(v.quell, v.ziel, int'(v.anzahl), int'(v.anzahl));
        stall_wort = v.stall_wort;
        stall_len = v.stall_len;
        basis = lesen_cnt;
        puls_start(v.quell, v.ziel, v.anzahl);
        pruefe("busy_nach_start", 32'(busy), 32'(v.anzahl != 0));
        if (v.anzahl == 0) pruefe("fertig_sofort", 32'(fertig), 32'd1);
        warte_ende("kopie", 400, dauer);
        pruefe("fertig", 32'(fertig), 32'(v.exp_fertig));
        pruefe("fehler", 32'(fehler), 32'(v.exp_fehler));
        pruefe("busy_ende", 32'(busy), 32'd0);
        pruefe("lesen_pulse", 32'(lesen_cnt - basis), 32'(v.anzahl));
        pruefe("ram_rest", 32'(ram_q.size()), 32'd0);
        pruefe("sd_rest", 32'(sd_q.size()), 32'd0);
        if (v.stall_len != 0) pruefe("stall_zyklen", 32'(stall_cnt), 32'(v.stall_len));
    endtask

    vec_t vek[5];

    initial begin
        int dauer, basis;
        vek[0] = '{32'h0000_0100, 32'h0000_2000, 16'd3, -1, 0, 1'b1, 1'b0};
        vek[1] = '{32'h0000_0000, 32'h0000_0040, 16'd0, -1, 0, 1'b1, 1'b0};
        vek[2] = '{32'h0000_0500, 32'h0000_3000, 16'd3,  1, 10, 1'b1, 1'b0};
        vek[3] = '{32'hFFFF_FFFF, 32'h0000_0010, 16'd2, -1, 0, 1'b1, 1'b0};
        vek[4] = '{32'h0000_0007, 32'hFFFF_FFFF, 16'd2, -1, 0, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        pruefe("reset_busy", 32'(busy), 32'd0);
        pruefe("reset_fertig", 32'(fertig), 32'd0);
        pruefe("reset_fehler", 32'(fehler), 32'd0);
        pruefe("reset_lesen", 32'(bus.sd_lesen), 32'd0);
        pruefe("reset_schreiben", 32'(bus.ram_schreiben), 32'd0);
        pruefe("reset_sd_adresse", bus.sd_adresse, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) kopie(vek[i]);

        // Dead card: data never arrives, the wait must time out.
        stall_wort = -1;
        stall_len = 0;
        sd_tot = 1'b1;
        sd_q.push_back(32'h0000_0040);
        puls_start(32'h0000_0040, 32'h0000_0080, 16'd2);
        warte_ende("timeout", 100, dauer);
        pruefe("timeout_fehler", 32'(fehler), 32'd1);
        pruefe("timeout_fertig", 32'(fertig), 32'd0);
        pruefe("timeout_busy", 32'(busy), 32'd0);
        pruefe("timeout_frueh", 32'(dauer >= 17), 32'd1);
        pruefe("timeout_spaet", 32'(dauer <= 21), 32'd1);
        sd_tot = 1'b0;
        repeat (3) @(negedge clk);
        puls_start(32'h0, 32'h0, 16'd0);
        pruefe("fehler_geloescht", 32'(fehler), 32'd0);
        pruefe("fertig_nach_fehler", 32'(fertig), 32'd1);

        // A second Start during a copy must be ignored.
        erwarte(32'h0000_0900, 32'h0000_4000, 2, 2);
        basis = lesen_cnt;
        puls_start(32'h0000_0900, 32'h0000_4000, 16'd2);
        repeat (2) @(negedge clk);
        puls_start(32'hDEAD_0000, 32'h0000_5555, 16'd7);
        warte_ende("start_ignoriert", 400, dauer);
        pruefe("ign_fertig", 32'(fertig), 32'd1);
        pruefe("ign_lesen", 32'(lesen_cnt - basis), 32'd2);
        pruefe("ign_ram_rest", 32'(ram_q.size()), 32'd0);

        // Reset during the second word of a wrapping copy.
        erwarte(32'hFFFF_FFFF, 32'h0000_0010, 2, 1);
        basis = lesen_cnt;
        puls_start(32'hFFFF_FFFF, 32'h0000_0010, 16'd2);
        dauer = 0;
        while (lesen_cnt < basis + 2 && dauer < 100) begin
            @(negedge clk);
            dauer++;
        end
        pruefe("reset_wort2_erreicht", 32'(lesen_cnt - basis), 32'd2);
        rst_n = 1'b0;
        #1;
        pruefe("mitte_busy", 32'(busy), 32'd0);
        pruefe("mitte_fertig", 32'(fertig), 32'd0);
        pruefe("mitte_fehler", 32'(fehler), 32'd0);
        pruefe("mitte_lesen", 32'(bus.sd_lesen), 32'd0);
        pruefe("mitte_schreiben", 32'(bus.ram_schreiben), 32'd0);
        pruefe("mitte_ram_adresse", bus.ram_adresse, 32'd0);
        pruefe("mitte_ram_daten", bus.ram_daten, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        pruefe("nach_reset_busy", 32'(busy), 32'd0);
        pruefe("nach_reset_sd_rest", 32'(sd_q.size()), 32'd0);
        pruefe("nach_reset_ram_rest", 32'(ram_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
